// File: rtl/i2s_master_tx.sv
// I2S master transmitter: derives BCLK/LRCK from iCLK and shifts stereo pairs out MSB first.
// Optional build macro I2S_TX_UNDERRUN_HOLD_EN repeats the last pair on underrun instead of sending silence.
module i2s_master_tx #(
    parameter int WS        = 16,  // sample width
    parameter int SLOT_BITS = 32,  // BCLK periods per channel slot, >= WS+1
    parameter int BCLK_HALF = 2    // iCLK cycles per BCLK half-period, >= 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iEnable,
    input  logic [WS-1:0] iL,
    input  logic [WS-1:0] iR,
    input  logic          iValid,
    output logic          oReady,
    output logic          oBCLK,
    output logic          oLRCK,
    output logic          oDAT,
    output logic          oUnderrun,
    output logic          oBusy
);

    localparam int FRAME = 2 * SLOT_BITS;
    localparam int BW    = $clog2(FRAME);
    localparam int DW    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int PW    = 2 * WS;

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);
    localparam logic [BW-1:0] SLOT_W   = BW'(SLOT_BITS);
    localparam logic [BW-1:0] WS_B     = BW'(WS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bitcnt_q, bitcnt_d;
    logic            bclk_q, bclk_d;
    logic            lrck_q, lrck_d;
    logic            dat_q, dat_d;
    logic            full_q, full_d;
    logic            ready_q, ready_d;
    logic            unr_q, unr_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   buf_q, buf_d;
    logic [PW-1:0]   sh_q, sh_d;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    logic [PW-1:0]   last_q, last_d;
`endif

    logic            accept;
    logic            start;
    logic [BW-1:0]   bitcnt_nx;
    logic            lrck_nx;
    logic [BW-1:0]   pos_nx;
    logic            in_word;

    // Position the next fall tick will present; LRCK and data are both derived from it.
    assign accept    = iValid && ready_q;
    assign bitcnt_nx = (bitcnt_q == BIT_LAST) ? '0 : bitcnt_q + BW'(1);
    assign lrck_nx   = (bitcnt_nx >= SLOT_W);
    assign pos_nx    = lrck_nx ? (bitcnt_nx - SLOT_W) : bitcnt_nx;
    assign in_word   = (pos_nx != '0) && (pos_nx <= WS_B);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        bclk_d   = bclk_q;
        lrck_d   = lrck_q;
        dat_d    = dat_q;
        busy_d   = busy_q;
        buf_d    = buf_q;
        sh_d     = sh_q;
        full_d   = full_q;
        unr_d    = 1'b0;
        start    = 1'b0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        last_d   = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (iEnable) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    div_d    = '0;
                    bitcnt_d = '0;
                    bclk_d   = 1'b0;
                    lrck_d   = 1'b0;
                    dat_d    = 1'b0;
                    start    = 1'b1;
                end
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    bclk_d = !bclk_q;
                    if (bclk_q) begin
                        if ((bitcnt_nx == '0) && !iEnable) begin
                            // Stop lands on a frame boundary; the buffered pair stays put.
                            state_d  = IDLE;
                            busy_d   = 1'b0;
                            bitcnt_d = '0;
                            lrck_d   = 1'b0;
                            dat_d    = 1'b0;
                        end else begin
                            bitcnt_d = bitcnt_nx;
                            lrck_d   = lrck_nx;
                            start    = (bitcnt_nx == '0);
                            if (in_word) begin
                                dat_d = sh_q[PW-1];
                                sh_d  = {sh_q[PW-2:0], 1'b0};
                            end else begin
                                dat_d = 1'b0;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            if (full_q) begin
                sh_d   = buf_q;
                full_d = 1'b0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                last_d = buf_q;
`endif
            end else begin
                unr_d = 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                sh_d  = last_q;
`else
                sh_d  = '0;
`endif
            end
        end

        // ready_q mirrors !full_q, so an accept can never coincide with a consume.
        if (accept) begin
            buf_d  = {iL, iR};
            full_d = 1'b1;
        end
        ready_d = !full_d;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bitcnt_q <= '0;
            bclk_q   <= 1'b0;
            lrck_q   <= 1'b0;
            dat_q    <= 1'b0;
            full_q   <= 1'b0;
            ready_q  <= 1'b1;
            unr_q    <= 1'b0;
            busy_q   <= 1'b0;
            buf_q    <= '0;
            sh_q     <= '0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
            last_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            bclk_q   <= bclk_d;
            lrck_q   <= lrck_d;
            dat_q    <= dat_d;
            full_q   <= full_d;
            ready_q  <= ready_d;
            unr_q    <= unr_d;
            busy_q   <= busy_d;
            buf_q    <= buf_d;
            sh_q     <= sh_d;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
            last_q   <= last_d;
`endif
        end
    end

    assign oReady    = ready_q;
    assign oBCLK     = bclk_q;
    assign oLRCK     = lrck_q;
    assign oDAT      = dat_q;
    assign oUnderrun = unr_q;
    assign oBusy     = busy_q;

endmodule
